// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multicycle control unit.
// States, opcode/funct codes and the packed datapath control bundle.
package control_unit_pkg;

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_FETCH_WAIT, S_DECODE,
        S_EXEC_R, S_WB_R, S_SH_LOAD, S_SH_DO, S_SH_WB,
        S_JR, S_ADDI_EX, S_ADDI_WB, S_MEM_ADDR,
        S_LW_RD, S_LW_WB, S_SW_WR, S_BR, S_J,
        S_EXC_OVF, S_EXC_OPC, S_EXC_JMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;

    localparam logic [2:0] SHC_LOAD = 3'b001;
    localparam logic [2:0] SHC_SLL  = 3'b010;
    localparam logic [2:0] SHC_SRL  = 3'b011;
    localparam logic [2:0] SHC_SRA  = 3'b100;

    localparam logic [1:0] PCS_ALU  = 2'd0;
    localparam logic [1:0] PCS_OUT  = 2'd1;
    localparam logic [1:0] PCS_JMP  = 2'd2;
    localparam logic [1:0] PCS_EXC  = 2'd3;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_SH  = 2'd2;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_SE   = 2'd2;
    localparam logic [1:0] SRCB_SE_2 = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dest;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [2:0] shift_ctrl;
        logic       epc_write;
    } ctrl_t;

    function automatic logic is_addsub(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational state-to-control decode for the multicycle datapath.
// Mostly Moore; branch PCwrite and arithmetic write-back RegWrite see flags.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  state_e     state_i,
    input  logic       last_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       overflow_i,
    input  logic       igual_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCS_ALU;
                ctrl_o.alu_src_b = SRCB_4;
                ctrl_o.alu_ctrl  = ALU_ADD;
            end
            S_FETCH_WAIT: ctrl_o.ir_write = last_i;
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_SE_2;
                ctrl_o.alu_ctrl  = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_ctrl  = (funct_i == FN_ADD) ? ALU_ADD :
                                   (funct_i == FN_SUB) ? ALU_SUB : ALU_AND;
            end
            S_WB_R: begin
                ctrl_o.reg_dest   = 1'b1;
                ctrl_o.mem_to_reg = M2R_ALU;
                ctrl_o.reg_write  = !(overflow_i && is_addsub(funct_i));
            end
            S_SH_LOAD: ctrl_o.shift_ctrl = SHC_LOAD;
            S_SH_DO: begin
                ctrl_o.shift_ctrl = (funct_i == FN_SLL) ? SHC_SLL :
                                    (funct_i == FN_SRL) ? SHC_SRL : SHC_SRA;
            end
            S_SH_WB: begin
                ctrl_o.reg_dest   = 1'b1;
                ctrl_o.mem_to_reg = M2R_SH;
                ctrl_o.reg_write  = 1'b1;
            end
            S_JR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_ctrl  = ALU_PASSA;
                ctrl_o.pc_source = PCS_ALU;
                ctrl_o.pc_write  = 1'b1;
            end
            S_ADDI_EX, S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SE;
                ctrl_o.alu_ctrl  = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.mem_to_reg = M2R_ALU;
                ctrl_o.reg_write  = !overflow_i;
            end
            S_LW_RD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = last_i;
            end
            S_LW_WB: begin
                ctrl_o.mem_to_reg = M2R_MDR;
                ctrl_o.reg_write  = 1'b1;
            end
            S_SW_WR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_BR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_ctrl  = ALU_SUB;
                ctrl_o.pc_source = PCS_OUT;
                ctrl_o.pc_write  = (opcode_i == OP_BNE) ? !igual_i : igual_i;
            end
            S_J: begin
                ctrl_o.pc_source = PCS_JMP;
                ctrl_o.pc_write  = 1'b1;
            end
            S_EXC_OVF, S_EXC_OPC: begin
                ctrl_o.alu_src_b = SRCB_4;
                ctrl_o.alu_ctrl  = ALU_SUB;
                ctrl_o.epc_write = 1'b1;
            end
            S_EXC_JMP: begin
                ctrl_o.pc_source = PCS_EXC;
                ctrl_o.pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: state register, memory wait counter, next-state.
// All datapath control wires come out of the decode sub-module.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Igual,
    output logic       PCwrite,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDest,
    output logic [1:0] MemToReg,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ShiftControl,
    output logic       EPCWrite
);

    localparam logic [1:0] LAST = 2'(MEM_WAIT - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       last;
    ctrl_t      ctrl;

    assign last = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_RST:        state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (last) state_d = S_DECODE;
                else      cnt_d   = cnt_q + 2'd1;
            end
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE: begin
                        case (FUNCT)
                            FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
                            FN_SLL, FN_SRL, FN_SRA: state_d = S_SH_LOAD;
                            FN_JR:                  state_d = S_JR;
                            default:                state_d = S_EXC_OPC;
                        endcase
                    end
                    OP_ADDI:        state_d = S_ADDI_EX;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_J;
                    default:        state_d = S_EXC_OPC;
                endcase
            end
            S_EXEC_R:  state_d = S_WB_R;
            S_WB_R: begin
                state_d = (Overflow && is_addsub(FUNCT)) ? S_EXC_OVF : S_FETCH;
            end
            S_SH_LOAD: state_d = S_SH_DO;
            S_SH_DO:   state_d = S_SH_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = Overflow ? S_EXC_OVF : S_FETCH;
            S_MEM_ADDR: begin
                state_d = (OPCODE == OP_SW) ? S_SW_WR : S_LW_RD;
            end
            S_LW_RD: begin
                if (last) state_d = S_LW_WB;
                else      cnt_d   = cnt_q + 2'd1;
            end
            S_EXC_OVF, S_EXC_OPC: state_d = S_EXC_JMP;
            S_SH_WB, S_JR, S_LW_WB, S_SW_WR,
            S_BR, S_J, S_EXC_JMP:  state_d = S_FETCH;
            default:               state_d = S_RST;
        endcase
    end

    control_unit_decode u_decode (
        .state_i    (state_q),
        .last_i     (last),
        .opcode_i   (OPCODE),
        .funct_i    (FUNCT),
        .overflow_i (Overflow),
        .igual_i    (Igual),
        .ctrl_o     (ctrl)
    );

    assign PCwrite      = ctrl.pc_write;
    assign PCSource     = ctrl.pc_source;
    assign IorD         = ctrl.iord;
    assign MemWrite     = ctrl.mem_write;
    assign MemRead      = ctrl.mem_read;
    assign IRWrite      = ctrl.ir_write;
    assign RegWrite     = ctrl.reg_write;
    assign RegDest      = ctrl.reg_dest;
    assign MemToReg     = ctrl.mem_to_reg;
    assign AluSrcA      = ctrl.alu_src_a;
    assign AluSrcB      = ctrl.alu_src_b;
    assign ALUControl   = ctrl.alu_ctrl;
    assign ShiftControl = ctrl.shift_ctrl;
    assign EPCWrite     = ctrl.epc_write;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected control sequences,
// checked cycle by cycle on two instances (one and two memory wait cycles).
module tb_control_unit;
    import control_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] opcode, funct;
    logic       ovf, igual;

    logic       pcw [2];
    logic [1:0] pcs [2];
    logic       iord [2];
    logic       mw [2];
    logic       mr [2];
    logic       irw [2];
    logic       rw [2];
    logic       rd [2];
    logic [1:0] m2r [2];
    logic       sa [2];
    logic [1:0] sb [2];
    logic [2:0] alu [2];
    logic [2:0] shc [2];
    logic       epcw [2];
    ctrl_t      got [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_unit #(.MEM_WAIT(g + 1)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .OPCODE       (opcode),
            .FUNCT        (funct),
            .Overflow     (ovf),
            .Igual        (igual),
            .PCwrite      (pcw[g]),
            .PCSource     (pcs[g]),
            .IorD         (iord[g]),
            .MemWrite     (mw[g]),
            .MemRead      (mr[g]),
            .IRWrite      (irw[g]),
            .RegWrite     (rw[g]),
            .RegDest      (rd[g]),
            .MemToReg     (m2r[g]),
            .AluSrcA      (sa[g]),
            .AluSrcB      (sb[g]),
            .ALUControl   (alu[g]),
            .ShiftControl (shc[g]),
            .EPCWrite     (epcw[g])
        );
        assign got[g] = {pcw[g], pcs[g], iord[g], mw[g], mr[g], irw[g],
                         rw[g], rd[g], m2r[g], sa[g], sb[g], alu[g],
                         shc[g], epcw[g]};
    end

    int    checks = 0;
    int    errors = 0;
    ctrl_t exp_q [$];

    task automatic chk(input string tag, input ctrl_t g, input ctrl_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%06h exp=%06h", tag, g, e);
        end
    endtask

    // Expected per-cycle control vectors for one instruction, from fetch on.
    task automatic gen(input logic [5:0] op, input logic [5:0] fn,
                       input logic ov, input logic ig, input int w);
        ctrl_t c;
        logic  trap;
        trap = 1'b0;
        exp_q.delete();
        c = '0; c.pc_write = 1; c.alu_src_b = 1; c.alu_ctrl = 1;
        exp_q.push_back(c);
        for (int i = 0; i < w; i++) begin
            c = '0; c.ir_write = (i == w - 1);
            exp_q.push_back(c);
        end
        c = '0; c.alu_src_b = 3; c.alu_ctrl = 1;
        exp_q.push_back(c);
        if (op == 0 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            c = '0; c.alu_src_a = 1;
            c.alu_ctrl = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
            exp_q.push_back(c);
            trap = ov && (fn != 6'h24);
            c = '0; c.reg_dest = 1; c.reg_write = !trap;
            exp_q.push_back(c);
        end else if (op == 0 && (fn == 0 || fn == 2 || fn == 3)) begin
            c = '0; c.shift_ctrl = 1;
            exp_q.push_back(c);
            c = '0; c.shift_ctrl = (fn == 0) ? 3'd2 : (fn == 2) ? 3'd3 : 3'd4;
            exp_q.push_back(c);
            c = '0; c.reg_dest = 1; c.mem_to_reg = 2; c.reg_write = 1;
            exp_q.push_back(c);
        end else if (op == 0 && fn == 6'h08) begin
            c = '0; c.alu_src_a = 1; c.pc_write = 1;
            exp_q.push_back(c);
        end else if (op == 6'h08) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2; c.alu_ctrl = 1;
            exp_q.push_back(c);
            trap = ov;
            c = '0; c.reg_write = !ov;
            exp_q.push_back(c);
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2; c.alu_ctrl = 1;
            exp_q.push_back(c);
            if (op == 6'h23) begin
                for (int i = 0; i < w; i++) begin
                    c = '0; c.iord = 1; c.mem_read = (i == w - 1);
                    exp_q.push_back(c);
                end
                c = '0; c.mem_to_reg = 1; c.reg_write = 1;
                exp_q.push_back(c);
            end else begin
                c = '0; c.iord = 1; c.mem_write = 1;
                exp_q.push_back(c);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.alu_src_a = 1; c.alu_ctrl = 2; c.pc_source = 1;
            c.pc_write = (op == 6'h04) ? ig : !ig;
            exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c = '0; c.pc_source = 2; c.pc_write = 1;
            exp_q.push_back(c);
        end else begin
            trap = 1'b1;
        end
        if (trap) begin
            c = '0; c.alu_src_b = 1; c.alu_ctrl = 2; c.epc_write = 1;
            exp_q.push_back(c);
            c = '0; c.pc_source = 3; c.pc_write = 1;
            exp_q.push_back(c);
        end
    endtask

    task automatic do_reset(input int w);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2 chk($sformatf("rst w%0d", w), got[w-1], '0);
        end
        reset = 1'b1;
    endtask

    // stop>0 aborts the instruction with a reset after that many cycles.
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input logic ov, input logic ig, input int w,
                       input int stop);
        int n;
        gen(op, fn, ov, ig, w);
        n = exp_q.size();
        if (stop > 0 && stop < n) n = stop;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            opcode = op; funct = fn; ovf = ov; igual = ig;
            #1 chk($sformatf("op%02h fn%02h ov%0d ig%0d w%0d cyc%0d",
                             op, fn, ov, ig, w, i), got[w-1], exp_q[i]);
        end
        if (n < exp_q.size()) do_reset(w);
    endtask

    localparam logic [5:0] OPS [16] = '{
        6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08,
        6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h00, 6'h0C
    };
    localparam logic [5:0] FNS [16] = '{
        6'h20, 6'h22, 6'h24, 6'h00, 6'h02, 6'h03, 6'h08, 6'h00,
        6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21, 6'h00
    };

    initial begin
        logic [5:0] op, fn;
        int         k, stop;
        reset = 1'b0; opcode = '0; funct = '0; ovf = 1'b0; igual = 1'b0;
        for (int w = 1; w <= 2; w++) begin
            do_reset(w);
            run(6'h00, 6'h20, 1'b0, 1'b0, w, 0);
            run(6'h00, 6'h20, 1'b1, 1'b0, w, 0);
            run(6'h00, 6'h22, 1'b1, 1'b0, w, 0);
            run(6'h00, 6'h24, 1'b1, 1'b0, w, 0);
            run(6'h04, 6'h00, 1'b0, 1'b1, w, 0);
            run(6'h04, 6'h00, 1'b0, 1'b0, w, 0);
            run(6'h05, 6'h00, 1'b0, 1'b0, w, 0);
            run(6'h05, 6'h00, 1'b0, 1'b1, w, 0);
            run(6'h23, 6'h00, 1'b0, 1'b0, w, 0);
            run(6'h2B, 6'h00, 1'b0, 1'b0, w, 0);
            run(6'h3F, 6'h00, 1'b0, 1'b0, w, 0);
            run(6'h00, 6'h03, 1'b0, 1'b0, w, 0);
            run(6'h00, 6'h08, 1'b0, 1'b0, w, 0);
            run(6'h02, 6'h00, 1'b0, 1'b0, w, 0);
            run(6'h08, 6'h11, 1'b1, 1'b0, w, 0);
            run(6'h00, 6'h21, 1'b0, 1'b0, w, 0);
            run(6'h23, 6'h00, 1'b0, 1'b0, w, 4 + w);
            for (int t = 0; t < 60; t++) begin
                k  = $urandom_range(0, 15);
                op = OPS[k];
                fn = (op == 6'h00) ? FNS[k] : 6'($urandom_range(0, 63));
                stop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 10) : 0;
                run(op, fn, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), w, stop);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
